axi_sram_slave: RTL and testbench

- AXI3-subset slave/responder that models the memory side of the CPU's AXI port. It is the target the CPU-side SRAM-to-AXI bridge talks to, and is used as the bench memory.
- Owns a 32-bit word array. Accepts single-beat reads (AR→R) and writes (AW+W→B).
- Read path and write path are independent FSMs. Each allows at most one outstanding transaction, and echoes the transaction id.

---
 rtl/axi_sram_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 SRAM responder with independent read and write FSMs.
// Define AXI_SLAVE_DELAY_EN to insert RESP_DELAY wait cycles before rvalid/bvalid.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int RESP_DELAY = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_RESP   = 2'd2;
  localparam logic [2:0] W_IDLE   = 3'd0;
  localparam logic [2:0] W_HAVE_A = 3'd1;
  localparam logic [2:0] W_HAVE_D = 3'd2;
  localparam logic [2:0] W_COMMIT = 3'd3;
  localparam logic [2:0] W_RESP   = 3'd5;

`ifdef AXI_SLAVE_DELAY_EN
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [2:0] W_WAIT = 3'd4;
  localparam logic [3:0] DELAY  = 4'(RESP_DELAY);
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
`else
  logic [3:0] unused_delay;
  assign unused_delay = 4'(RESP_DELAY);
`endif

  logic [31:0]           mem [DEPTH];
  logic [1:0]            r_state;
  logic [2:0]            w_state;
  logic [ADDR_WIDTH-1:0] ar_idx;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  unused_ok;

  // Upper address bits alias and byte offsets are dropped; burst fields are ignored.
  assign ar_idx    = araddr[ADDR_WIDTH+1:2];
  assign aw_idx    = awaddr[ADDR_WIDTH+1:2];
  assign unused_ok = ^{arlen, arsize, arburst, awlen, awsize, awburst, wid, wlast,
                       araddr, awaddr};

  assign arready = aresetn && (r_state == R_IDLE);
  assign rvalid  = aresetn && (r_state == R_RESP);
  assign rlast   = rvalid;
  assign rresp   = 2'b00;
  assign awready = aresetn && (w_state == W_IDLE || w_state == W_HAVE_D);
  assign wready  = aresetn && (w_state == W_IDLE || w_state == W_HAVE_A);
  assign bvalid  = aresetn && (w_state == W_RESP);
  assign bresp   = 2'b00;

  // Read FSM: rdata is captured from the array on the edge entering R_RESP.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          rid <= arid;
`ifdef AXI_SLAVE_DELAY_EN
          if (DELAY != 4'd0) begin
            r_idx   <= ar_idx;
            r_cnt   <= DELAY - 4'd1;
            r_state <= R_WAIT;
          end else begin
            rdata   <= mem[ar_idx];
            r_state <= R_RESP;
          end
`else
          rdata   <= mem[ar_idx];
          r_state <= R_RESP;
`endif
        end
`ifdef AXI_SLAVE_DELAY_EN
        R_WAIT: if (r_cnt == 4'd0) begin
          rdata   <= mem[r_idx];
          r_state <= R_RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
`endif
        R_RESP: if (rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: address and data may arrive in either order or together.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            bid   <= awid;
            w_idx <= aw_idx;
          end
          if (wvalid) begin
            w_data <= wdata;
            w_strb <= wstrb;
          end
          if (awvalid && wvalid) w_state <= W_COMMIT;
          else if (awvalid)      w_state <= W_HAVE_A;
          else if (wvalid)       w_state <= W_HAVE_D;
        end
        W_HAVE_A: if (wvalid) begin
          w_data  <= wdata;
          w_strb  <= wstrb;
          w_state <= W_COMMIT;
        end
        W_HAVE_D: if (awvalid) begin
          bid     <= awid;
          w_idx   <= aw_idx;
          w_state <= W_COMMIT;
        end
        W_COMMIT: begin
`ifdef AXI_SLAVE_DELAY_EN
          if (DELAY != 4'd0) begin
            w_cnt   <= DELAY - 4'd1;
            w_state <= W_WAIT;
          end else begin
            w_state <= W_RESP;
          end
`else
          w_state <= W_RESP;
`endif
        end
`ifdef AXI_SLAVE_DELAY_EN
        W_WAIT: if (w_cnt == 4'd0) w_state <= W_RESP;
                else w_cnt <= w_cnt - 4'd1;
`endif
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array is never reset; a commit interrupted by reset is dropped.
  always_ff @(posedge aclk) begin
    if (aresetn && w_state == W_COMMIT) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table, corner-case sequences,
// and randomized traffic checked against an associative-array memory model.
module tb_axi_sram_slave;
  localparam int AW = 12;
  localparam int DEPTH = 1 << AW;
`ifdef AXI_SLAVE_DELAY_EN
  localparam int D = 3;
`else
  localparam int D = 0;
`endif
  localparam int RLAT = 1 + D;
  localparam int WLAT = 2 + D;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(.ADDR_WIDTH(AW), .RESP_DELAY(3)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int];

  typedef struct {
    logic [3:0]  wr_id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  rd_id;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int w;
    logic [31:0] v;
    w = word_of(addr);
    v = model.exists(w) ? model[w] : 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    model[w] = v;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    @(negedge aclk);
    awvalid = 1'b1; awid = id; awaddr = addr;
    wvalid = 1'b1; wdata = data; wstrb = strb; wid = id;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    chk("aw_w_accept", 32'(awready && wready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 1;
    while (!bvalid && n < 40) begin @(negedge aclk); n++; end
    chk("wr_latency", 32'(n), 32'(WLAT));
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("bid_hold", 32'(bid), 32'(id));
      chk("awready_in_resp", 32'(awready || wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
    model_write(addr, data, strb);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] exp,
                          input int hold);
    int n;
    @(negedge aclk);
    arvalid = 1'b1; arid = id; araddr = addr;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    chk("ar_accept", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin @(negedge aclk); n++; end
    chk("rd_latency", 32'(n), 32'(RLAT));
    chk("rid", 32'(rid), 32'(id));
    chk("rdata", rdata, exp);
    chk("rlast", 32'(rlast), 32'd1);
    chk("rresp", 32'(rresp), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("rvalid_hold", 32'(rvalid), 32'd1);
      chk("rid_hold", 32'(rid), 32'(id));
      chk("rdata_hold", rdata, exp);
      chk("arready_in_resp", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    chk("arready_at_rhs", 32'(arready), 32'd0);
    @(negedge aclk);
    rready = 1'b0;
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got_r, got_b;
    logic [31:0] r_cap, exp_v;

    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0; bready = 1'b0;

    vecs[0] = '{4'd1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4'd0, 32'hDEAD_BEEF};
    vecs[1] = '{4'd2, 32'h0000_0020, 32'h1122_3344, 4'hF, 4'd1, 32'h1122_3344};
    vecs[2] = '{4'd3, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 4'd2, 32'h11BB_33DD};
    vecs[3] = '{4'd4, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 4'd3, 32'hCAFE_F00D};
    vecs[4] = '{4'd5, 32'h0000_0024, 32'h0000_0000, 4'h0, 4'd4, 32'hCAFE_F00D};
    vecs[5] = '{4'd6, 32'h0000_0024, 32'h1234_5678, 4'b1000, 4'd5, 32'h12FE_F00D};
    vecs[6] = '{4'd7, 32'h0000_4024, 32'hFFFF_FFFF, 4'b0010, 4'd6, 32'h12FE_FF0D};
    vecs[7] = '{4'd8, 32'h0000_0027, 32'h0000_0000, 4'b0001, 4'd7, 32'h12FE_FF00};
    vecs[8] = '{4'd9, 32'h0000_3FFC, 32'h0BAD_C0DE, 4'hF, 4'd15, 32'h0BAD_C0DE};

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_ready", 32'({arready, awready, wready}), 32'd7);

    // Vector table: write then read back
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].wr_id, vecs[i].addr, vecs[i].data, vecs[i].strb, 0);
      axi_read(vecs[i].rd_id, vecs[i].addr, vecs[i].exp, 0);
    end

    // W before AW
    @(negedge aclk);
    wvalid = 1'b1; wdata = 32'h5A5A_1234; wstrb = 4'hF;
    chk("w_first_wready", 32'(wready), 32'd1);
    @(negedge aclk);
    wvalid = 1'b0;
    chk("wready_t1", 32'(wready), 32'd0);
    @(negedge aclk);
    chk("wready_t2", 32'(wready), 32'd0);
    @(negedge aclk);
    chk("wready_t3", 32'(wready), 32'd0);
    chk("awready_have_d", 32'(awready), 32'd1);
    awvalid = 1'b1; awid = 4'd1; awaddr = 32'h30;
    @(negedge aclk);
    awvalid = 1'b0;
    n = 1;
    while (!bvalid && n < 40) begin @(negedge aclk); n++; end
    chk("w_first_latency", 32'(n), 32'(WLAT));
    chk("w_first_bid", 32'(bid), 32'd1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    model_write(32'h30, 32'h5A5A_1234, 4'hF);
    axi_read(4'd2, 32'h30, 32'h5A5A_1234, 0);

    // Backpressure
    axi_read(4'd5, 32'h10, 32'hDEAD_BEEF, 4);
    axi_write(4'd6, 32'h50, 32'h7777_8888, 4'hF, 4);
    axi_read(4'd6, 32'h50, 32'h7777_8888, 0);

    // Collision: AR one cycle after AW+W, so read sample and commit share an edge
    axi_write(4'd0, 32'h40, 32'h0101_0101, 4'hF, 0);
    @(negedge aclk);
    awvalid = 1'b1; awid = 4'd9; awaddr = 32'h40;
    wvalid = 1'b1; wdata = 32'hF0F0_F0F0; wstrb = 4'hF;
    chk("coll_aw_ready", 32'(awready && wready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; arid = 4'd10; araddr = 32'h40;
    chk("coll_ar_ready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    got_r = 1'b0; got_b = 1'b0; r_cap = '0;
    for (int i = 0; i < 20 && !(got_r && got_b); i++) begin
      if (rvalid && !got_r) begin got_r = 1'b1; r_cap = rdata; end
      if (bvalid) got_b = 1'b1;
      @(negedge aclk);
    end
    rready = 1'b0; bready = 1'b0;
    chk("coll_got_r", 32'(got_r), 32'd1);
    chk("coll_got_b", 32'(got_b), 32'd1);
    exp_v = (D == 0) ? 32'h0101_0101 : 32'hF0F0_F0F0;
    chk("coll_rdata", r_cap, exp_v);
    model_write(32'h40, 32'hF0F0_F0F0, 4'hF);
    @(negedge aclk);
    axi_read(4'd11, 32'h40, 32'hF0F0_F0F0, 0);

    // Reset while in R_RESP
    @(negedge aclk);
    arvalid = 1'b1; arid = 4'd3; araddr = 32'h10;
    @(negedge aclk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin @(negedge aclk); n++; end
    chk("mid_rvalid", 32'(rvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge aclk);
    chk("mid_rst_rvalid2", 32'(rvalid), 32'd0);
    chk("mid_rst_arready2", 32'(arready), 32'd0);
    chk("mid_rst_rid", 32'(rid), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_rel_arready", 32'(arready), 32'd1);
    chk("mid_rel_rvalid", 32'(rvalid), 32'd0);
    axi_read(4'd4, 32'h10, 32'hDEAD_BEEF, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 16; k++) axi_write(4'(k), 32'((64 + k) * 4), $urandom, 4'hF, 0);
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      logic [3:0] id;
      a  = (32'(64 + $urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
           | (32'($urandom_range(0, 7)) << (AW + 2));
      id = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(id, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      else
        axi_read(id, a, model[word_of(a)], $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
